pc_sequencer: RTL and testbench

- Parametrised next-generation fetch program counter for the MIPS32 core.
- Adds the following to plain sequential/jump behaviour:
  - relative branches
  - J-type absolute jumps
  - register jumps with alignment checking
  - an exception vector and EPC capture, with ERET return
  - stall support with a one-entry pending-redirect buffer
- Sits at the head of the fetch stage. Its output drives instruction memory; redirect inputs come from decode/execute.

---
 rtl/mips_pkg.sv | 10 +
 rtl/pc_target_calc.sv | 36 +++
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared defaults and enum types for the MIPS32 fetch PC sequencer.
// Holds the default address width, reset and exception fetch addresses,
// the FSM state type and the redirect-source type.
package mips_pkg;
   localparam int          ADDR_W_DEF     = 32;
   localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
   typedef enum logic {RUN, HELD} pc_state_e;
   typedef enum logic [2:0] {SRC_SEQ, SRC_BR, SRC_J, SRC_JR, SRC_ERET, SRC_EXC} redir_src_e;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational next-fetch-address candidates.
// Ports:
//   pc_i            current word address
//   branch_offset_i signed word offset, relative to pc_i+1
//   jump_index_i    J-type instr_index field
//   jr_target_i     register-jump byte address
//   seq_o/br_o/j_o/jr_o  candidate word addresses, modulo 2^(ADDR_W-2)
//   jr_misaligned_o jr_target_i is not word-aligned
module pc_target_calc
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-3:0] pc_i,
   input  logic [15:0]       branch_offset_i,
   input  logic [25:0]       jump_index_i,
   input  logic [ADDR_W-1:0] jr_target_i,
   output logic [ADDR_W-3:0] seq_o,
   output logic [ADDR_W-3:0] br_o,
   output logic [ADDR_W-3:0] j_o,
   output logic [ADDR_W-3:0] jr_o,
   output logic              jr_misaligned_o
);
   assign seq_o           = pc_i + {{(ADDR_W-3){1'b0}}, 1'b1};
   assign br_o            = seq_o + {{(ADDR_W-18){branch_offset_i[15]}}, branch_offset_i};
   assign jr_o            = jr_target_i[ADDR_W-1:2];
   assign jr_misaligned_o = |jr_target_i[1:0];
   // The 256 MB region bits come from seq; a 28-bit core has no region bits.
   generate
      if (ADDR_W > 28) begin : g_region
         assign j_o = {seq_o[ADDR_W-3:26], jump_index_i};
      end else begin : g_flat
         assign j_o = jump_index_i;
      end
   endgenerate
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with branch/jump/jr/eret redirects and exceptions.
// Ports:
//   clock, reset       clock and synchronous active-high reset
//   stall              hold the PC; a redirect seen while stalled is buffered
//   branch_taken/branch_offset  relative branch request
//   jump_enable/jump_index      J-type request
//   jr_enable/jr_target         register jump (misaligned target raises an exception)
//   exception, eret             exception entry and return
//   pc_value, epc               fetch word address and saved exception PC
//   redirect_pending            a redirect is buffered while stalled
//   align_fault                 one-cycle pulse for a misaligned jr_target
module pc_sequencer
   import mips_pkg::*;
#(
   parameter int          ADDR_W     = ADDR_W_DEF,
   parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [15:0]       branch_offset,
   input  logic              jump_enable,
   input  logic [25:0]       jump_index,
   input  logic              jr_enable,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              exception,
   input  logic              eret,
   output logic [ADDR_W-3:0] pc_value,
   output logic [ADDR_W-3:0] epc,
   output logic              redirect_pending,
   output logic              align_fault
);
   logic [ADDR_W-3:0] pc_q, pc_d, epc_q, epc_d, pend_q, pend_d;
   logic [ADDR_W-3:0] seq_w, br_w, j_w, jr_w, tgt;
   pc_state_e         state_q, state_d;
   redir_src_e        src;
   logic              align_q, align_d, jr_mis, jr_bad, req;

   pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
      .pc_i           (pc_q),
      .branch_offset_i(branch_offset),
      .jump_index_i   (jump_index),
      .jr_target_i    (jr_target),
      .seq_o          (seq_w),
      .br_o           (br_w),
      .j_o            (j_w),
      .jr_o           (jr_w),
      .jr_misaligned_o(jr_mis)
   );

   assign jr_bad = jr_enable & jr_mis;
   assign src = (exception | jr_bad) ? SRC_EXC  :
                eret                 ? SRC_ERET :
                jr_enable            ? SRC_JR   :
                jump_enable          ? SRC_J    :
                branch_taken         ? SRC_BR   : SRC_SEQ;
   assign req = src inside {SRC_BR, SRC_J, SRC_JR, SRC_ERET};
   assign tgt = src == SRC_ERET ? epc_q :
                src == SRC_JR   ? jr_w  :
                src == SRC_J    ? j_w   : br_w;

   // Exceptions ignore stall and flush the buffer; in HELD a stalled cycle
   // ignores new redirects so the first buffered one wins.
   always_comb begin
      pc_d    = pc_q;
      epc_d   = epc_q;
      pend_d  = pend_q;
      state_d = state_q;
      align_d = jr_bad;
      if (src == SRC_EXC) begin
         pc_d    = EXC_VECTOR[ADDR_W-1:2];
         epc_d   = pc_q;
         pend_d  = '0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (!stall) pc_d = req ? tgt : seq_w;
         else if (req) begin
            pend_d  = tgt;
            state_d = HELD;
         end
      end else if (!stall) begin
         pc_d    = req ? tgt : pend_q;
         state_d = RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q    <= RESET_ADDR[ADDR_W-1:2];
         epc_q   <= '0;
         pend_q  <= '0;
         state_q <= RUN;
         align_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         align_q <= align_d;
      end
   end

   assign pc_value         = pc_q;
   assign epc              = epc_q;
   assign redirect_pending = state_q == HELD;
   assign align_fault      = align_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table, corner sequences and randomized model check for pc_sequencer.
module tb_pc_sequencer;
   logic        clock = 1'b0;
   logic        rst_a, rst_b;
   logic        stall, branch_taken, jump_enable, jr_enable, exception, eret;
   logic [15:0] branch_offset;
   logic [25:0] jump_index;
   logic [31:0] jr_target;
   logic [29:0] pc_a, epc_a;
   logic [25:0] pc_b, epc_b;
   logic        pend_a, af_a, pend_b, af_b;
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   pc_sequencer u_a (
      .clock(clock), .reset(rst_a), .stall(stall),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump_enable(jump_enable), .jump_index(jump_index),
      .jr_enable(jr_enable), .jr_target(jr_target),
      .exception(exception), .eret(eret),
      .pc_value(pc_a), .epc(epc_a), .redirect_pending(pend_a), .align_fault(af_a)
   );

   pc_sequencer #(.ADDR_W(28)) u_b (
      .clock(clock), .reset(rst_b), .stall(stall),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump_enable(jump_enable), .jump_index(jump_index),
      .jr_enable(jr_enable), .jr_target(jr_target[27:0]),
      .exception(exception), .eret(eret),
      .pc_value(pc_b), .epc(epc_b), .redirect_pending(pend_b), .align_fault(af_b)
   );

   typedef struct {
      bit          stall, br;
      logic [15:0] off;
      bit          j;
      logic [25:0] idx;
      bit          jr;
      logic [31:0] jrt;
      bit          exc, eret;
      logic [31:0] pc, epc;
      bit          pend, af;
   } vec_t;

   // Byte-address model state: pv/pt is the one-entry redirect buffer.
   typedef struct {
      logic [31:0] pc, epc, pt;
      bit          pv, af;
   } ms_t;

   ms_t sa, sb;

   function automatic vec_t mk(bit st, bit br, logic [15:0] off, bit j, logic [25:0] idx,
                               bit jr, logic [31:0] jrt, bit exc, bit er,
                               logic [31:0] pc, logic [31:0] epc, bit pend, bit af);
      vec_t v;
      v.stall = st; v.br = br; v.off = off; v.j = j; v.idx = idx; v.jr = jr; v.jrt = jrt;
      v.exc = exc; v.eret = er; v.pc = pc; v.epc = epc; v.pend = pend; v.af = af;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      stall = 0; branch_taken = 0; branch_offset = '0; jump_enable = 0; jump_index = '0;
      jr_enable = 0; jr_target = '0; exception = 0; eret = 0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic mstep(input int aw, input bit rst, inout ms_t s);
      logic [31:0] m, seq, t;
      bit          bad, req;
      m   = (aw == 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
      seq = (s.pc + 32'd4) & m;
      bad = jr_enable && (jr_target[1:0] != 2'b00);
      if (rst) begin
         s.pc = 32'h3000; s.epc = '0; s.pv = 0; s.pt = '0; s.af = 0;
      end else begin
         s.af = bad;
         if (exception || bad) begin
            s.epc = s.pc; s.pc = 32'h4180 & m; s.pv = 0;
         end else begin
            req = eret || jr_enable || jump_enable || branch_taken;
            t = eret        ? s.epc :
                jr_enable   ? (jr_target & m) :
                jump_enable ? (((seq & ~32'h0FFF_FFFF) | {4'b0, jump_index, 2'b00}) & m) :
                              ((seq + {{14{branch_offset[15]}}, branch_offset, 2'b00}) & m);
            if (stall) begin
               if (req && !s.pv) begin s.pv = 1; s.pt = t; end
            end else begin
               s.pc = req ? t : (s.pv ? s.pt : seq);
               s.pv = 0;
            end
         end
      end
   endtask

   vec_t tbl[20];

   initial begin
      tbl[0]  = mk(0,0,16'h0000,0,26'h0,0,32'h0,0,0, 32'h3004,32'h0,0,0);
      tbl[1]  = mk(0,0,16'h0000,0,26'h0,0,32'h0,0,0, 32'h3008,32'h0,0,0);
      tbl[2]  = mk(0,0,16'h0000,0,26'h0,0,32'h0,0,0, 32'h300C,32'h0,0,0);
      tbl[3]  = mk(0,0,16'h0000,0,26'h0,0,32'h0,0,0, 32'h3010,32'h0,0,0);
      tbl[4]  = mk(0,1,16'hFFFE,0,26'h0,0,32'h0,0,0, 32'h300C,32'h0,0,0);
      tbl[5]  = mk(0,0,16'h0000,1,26'h100,0,32'h0,0,0, 32'h0400,32'h0,0,0);
      tbl[6]  = mk(1,0,16'h0000,0,26'h0,1,32'h5000,0,0, 32'h0400,32'h0,1,0);
      tbl[7]  = mk(1,0,16'h0000,1,26'h200,0,32'h0,0,0, 32'h0400,32'h0,1,0);
      tbl[8]  = mk(0,0,16'h0000,0,26'h0,0,32'h0,0,0, 32'h5000,32'h0,0,0);
      tbl[9]  = mk(0,0,16'h0000,0,26'h0,1,32'h3020,0,0, 32'h3020,32'h0,0,0);
      tbl[10] = mk(0,0,16'h0000,0,26'h0,1,32'h5002,0,0, 32'h4180,32'h3020,0,1);
      tbl[11] = mk(0,0,16'h0000,0,26'h0,0,32'h0,0,1, 32'h3020,32'h3020,0,0);
      tbl[12] = mk(1,1,16'h0010,0,26'h0,0,32'h0,0,0, 32'h3020,32'h3020,1,0);
      tbl[13] = mk(1,0,16'h0000,0,26'h0,0,32'h0,1,0, 32'h4180,32'h3020,0,0);
      tbl[14] = mk(0,0,16'h0000,0,26'h0,0,32'h0,0,0, 32'h4184,32'h3020,0,0);
      tbl[15] = mk(0,0,16'h0000,0,26'h0,0,32'h0,1,1, 32'h4180,32'h4184,0,0);
      tbl[16] = mk(0,0,16'h0000,0,26'h0,0,32'h0,0,1, 32'h4184,32'h4184,0,0);
      tbl[17] = mk(1,1,16'h0000,0,26'h0,0,32'h0,0,0, 32'h4184,32'h4184,1,0);
      tbl[18] = mk(0,0,16'h0000,1,26'h10,0,32'h0,0,0, 32'h0040,32'h4184,0,0);
      tbl[19] = mk(1,0,16'h0000,0,26'h0,0,32'h0,0,0, 32'h0040,32'h4184,0,0);

      idle();
      rst_a = 1; rst_b = 1;
      step(); step();
      rst_a = 0;
      chk("reset_pc", {pc_a, 2'b00}, 32'h3000);
      chk("reset_epc", {epc_a, 2'b00}, 32'h0);
      chk("reset_pend", {31'b0, pend_a}, 32'h0);
      chk("reset_af", {31'b0, af_a}, 32'h0);
      chk("reset_b_pc", {4'b0, pc_b, 2'b00}, 32'h3000);

      foreach (tbl[i]) begin
         stall = tbl[i].stall; branch_taken = tbl[i].br; branch_offset = tbl[i].off;
         jump_enable = tbl[i].j; jump_index = tbl[i].idx; jr_enable = tbl[i].jr;
         jr_target = tbl[i].jrt; exception = tbl[i].exc; eret = tbl[i].eret;
         step();
         chk($sformatf("tbl%0d_pc", i), {pc_a, 2'b00}, tbl[i].pc);
         chk($sformatf("tbl%0d_epc", i), {epc_a, 2'b00}, tbl[i].epc);
         chk($sformatf("tbl%0d_pend", i), {31'b0, pend_a}, {31'b0, tbl[i].pend});
         chk($sformatf("tbl%0d_af", i), {31'b0, af_a}, {31'b0, tbl[i].af});
      end

      // 28-bit instance: wrap-around and reset while a redirect is buffered.
      idle();
      rst_a = 1; rst_b = 0;
      jr_enable = 1; jr_target = 32'h0FFF_FFFC;
      step();
      chk("b_jr_top", {4'b0, pc_b, 2'b00}, 32'h0FFF_FFFC);
      idle();
      step();
      chk("b_wrap", {4'b0, pc_b, 2'b00}, 32'h0);
      step();
      chk("b_after_wrap", {4'b0, pc_b, 2'b00}, 32'h4);
      stall = 1; branch_taken = 1; branch_offset = 16'h0100;
      step();
      chk("b_held_pc", {4'b0, pc_b, 2'b00}, 32'h4);
      chk("b_held_pend", {31'b0, pend_b}, 32'h1);
      branch_taken = 0; rst_b = 1;
      step();
      chk("b_rst_pc", {4'b0, pc_b, 2'b00}, 32'h3000);
      chk("b_rst_pend", {31'b0, pend_b}, 32'h0);
      rst_b = 0; stall = 0;
      step();
      chk("b_post_rst", {4'b0, pc_b, 2'b00}, 32'h3004);

      // Randomized run of both widths against the byte-address model.
      idle();
      rst_a = 1; rst_b = 1;
      step();
      mstep(32, 1, sa); mstep(28, 1, sb);
      for (int n = 0; n < 3000; n++) begin
         bit r;
         r = ($urandom_range(0, 99) == 0);
         rst_a = r; rst_b = r;
         stall = ($urandom_range(0, 9) < 3);
         branch_taken = ($urandom_range(0, 4) == 0);
         branch_offset = 16'($urandom);
         jump_enable = ($urandom_range(0, 9) == 0);
         jump_index = 26'($urandom);
         jr_enable = ($urandom_range(0, 9) == 0);
         jr_target = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         exception = ($urandom_range(0, 39) == 0);
         eret = ($urandom_range(0, 19) == 0);
         step();
         mstep(32, r, sa); mstep(28, r, sb);
         chk("rnd_a_pc", {pc_a, 2'b00}, sa.pc);
         chk("rnd_a_epc", {epc_a, 2'b00}, sa.epc);
         chk("rnd_a_pend", {31'b0, pend_a}, {31'b0, sa.pv});
         chk("rnd_a_af", {31'b0, af_a}, {31'b0, sa.af});
         chk("rnd_b_pc", {4'b0, pc_b, 2'b00}, sb.pc);
         chk("rnd_b_epc", {4'b0, epc_b, 2'b00}, sb.epc);
         chk("rnd_b_pend", {31'b0, pend_b}, {31'b0, sb.pv});
         chk("rnd_b_af", {31'b0, af_b}, {31'b0, sb.af});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
